hrm_ctrl_seq: RTL and testbench
===============================

// Module: hrm_ctrl_seq
// PURPOSE
//  Parametrised successor control sequencer for the HRM CPU. Decodes the instruction register,
//  drives datapath strobes, stalls on INBOX/OUTBOX handshakes, supports indirect operands,
//  single-step debug, stall timeout and a retired-instruction counter. Sits between PROG/IR and datapath.
// PARAMETERS
//  INSTR_W  8  instruction width; opcode = INSTR[INSTR_W-1 -: 4], indirect flag = INSTR[INSTR_W-5]
//  CNT_W    16 width of retired-instruction counter (wraps)
//  STALL_W  8  width of stall counter; timeout when count reaches STALL_LIMIT
//  STALL_LIMIT 200 stall cycles before stall_to asserts (0 disables)
// PORTS
//  clk       in  1  clock, rising edge
//  i_rst     in  1  asynchronous reset, active-low (0 = reset)
//  INSTR     in  INSTR_W  instruction word from program memory
//  inEmpty   in  1  INBOX empty
//  outFull   in  1  OUTBOX full
//  zero, neg in  1  R==0 / R<0 flags for JUMPZ/JUMPN
//  debug     in  1  single-step mode enable
//  nxtInstr  in  1  step request (level, edge-detected internally)
//  wIR wR wM wAR wPC rIn wO  out 1  load/write strobes, one cycle each
//  muxR      out 2  R source: 00 INBOX, 01 MEM, 10 ALU, 11 immediate
//  srcA      out 1  AR source: 0 INSTR operand, 1 MEM (indirect)
//  aluCtl    out 3  000 ADD, 001 SUB, 010 INC, 011 DEC, others reserved
//  ijump     out 1  PC loads jump target; branch out 1 conditional jump taken
//  halt      out 1  CPU halted (sticky)
//  stall_to  out 1  stall timeout flag (sticky until reset)
//  instr_cnt out CNT_W retired instructions
// BEHAVIOUR
//  - Reset (i_rst=0, async): state=FETCH, all strobes/muxR/aluCtl/srcA=0, halt=0, stall_to=0, counters=0.
//  - Outputs are Moore, decoded from state + latched opcode; no combinational path from INSTR.
//  - FETCH: wIR=1 -> DECODE. DECODE: memory ops (COPYFROM/TO, ADD, SUB, BUMP+/-) -> ADDR.
//  - ADDR: wAR=1, srcA=0; if indirect flag -> INDIR (wAR=1, srcA=1, 1 extra cycle) else EXEC.
//  - INBOX: wait while inEmpty; first cycle inEmpty=0 -> rIn=1, wR=1, muxR=00, wPC=1.
//  - OUTBOX: wait while outFull; first cycle outFull=0 -> wO=1, wPC=1.
//  - COPYFROM: wR=1 muxR=01. COPYTO: wM=1. ADD/SUB: wR=1 muxR=10 aluCtl=000/001.
//    BUMP+/BUMP-: wR=1 wM=1 muxR=10 aluCtl=010/011. All assert wPC=1 in the same cycle.
//  - JUMP: ijump=1 wPC=1. JUMPZ/JUMPN: if zero/neg then branch=1 ijump=1 wPC=1, else wPC=1 only.
//  - SET (1110): wR=1 muxR=11 wPC=1. NOP (1011-1101): wPC=1 only.
//  - HALT (1111): enter HALT, halt=1, all strobes 0; leave only by reset.
//  - Latency: non-stalled direct op 3 cycles (FETCH, DECODE/ADDR, EXEC); indirect +1; jump/NOP/SET 3.
//  - instr_cnt increments once per cycle with wPC=1; wraps 2^CNT_W-1 -> 0.
//  - Stall counter counts consecutive INBOX/OUTBOX wait cycles, clears on exit; saturates;
//    stall_to sets when count==STALL_LIMIT; CPU keeps waiting (no abort).
//  - debug=1: after each wPC cycle go to STEP; stay until rising edge of nxtInstr, then FETCH.
//    nxtInstr held high does not double-step. debug=0 while in STEP -> FETCH next cycle.
//  - HALT takes precedence over STEP; reset mid-instruction abandons it with no strobes emitted.
// TESTING
//  - Reset: i_rst=0 async mid-EXEC -> all outputs 0 same cycle; after release first cycle wIR=1.
//  - INBOX with inEmpty=1 for 15 cycles then 0 -> rIn=wR=wPC=1 exactly once, muxR=00, instr_cnt=1.
//  - INSTR=8'h28 (COPYTO indirect) -> wAR srcA=0, wAR srcA=1, wM=1 in consecutive cycles.
//  - JUMPZ with zero=0 -> wPC=1 branch=0; zero=1 -> branch=ijump=wPC=1.
//  - OUTBOX with outFull=1 for 250 cycles -> stall_to=1 at wait cycle 200, wO=1 after release.
//  - debug=1, pulse nxtInstr 3 times -> exactly 3 instructions retire; INSTR=8'hF0 -> halt=1 sticky.

Source files
------------

// File: rtl/hrm_ctrl_seq_if.sv
// Bus between the HRM control sequencer and the PROG/IR/datapath side.
// master = sequencer, slave = datapath/program side.
interface hrm_ctrl_seq_if #(
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned CNT_W   = 16
);
  logic [INSTR_W-1:0] INSTR;
  logic               inEmpty;
  logic               outFull;
  logic               zero;
  logic               neg;
  logic               debug;
  logic               nxtInstr;
  logic               wIR;
  logic               wR;
  logic               wM;
  logic               wAR;
  logic               wPC;
  logic               rIn;
  logic               wO;
  logic [1:0]         muxR;
  logic               srcA;
  logic [2:0]         aluCtl;
  logic               ijump;
  logic               branch;
  logic               halt;
  logic               stall_to;
  logic [CNT_W-1:0]   instr_cnt;

  modport master (
    input  INSTR, inEmpty, outFull, zero, neg, debug, nxtInstr,
    output wIR, wR, wM, wAR, wPC, rIn, wO, muxR, srcA, aluCtl, ijump, branch,
           halt, stall_to, instr_cnt
  );

  modport slave (
    output INSTR, inEmpty, outFull, zero, neg, debug, nxtInstr,
    input  wIR, wR, wM, wAR, wPC, rIn, wO, muxR, srcA, aluCtl, ijump, branch,
           halt, stall_to, instr_cnt
  );
endinterface

// File: rtl/hrm_ctrl_seq.sv
// HRM CPU control sequencer: decodes the instruction word and emits registered one-cycle
// datapath strobes, with INBOX/OUTBOX stalls, indirect operands, single-step and halt.
module hrm_ctrl_seq #(
  parameter int unsigned INSTR_W     = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STALL_W     = 8,
  parameter int unsigned STALL_LIMIT = 200
) (
  input logic            clk,
  input logic            i_rst,
  hrm_ctrl_seq_if.master bus
);

  // Opcode map; 1011..1101 decode as NOP.
  localparam logic [3:0] OpInbox    = 4'h0;
  localparam logic [3:0] OpOutbox   = 4'h1;
  localparam logic [3:0] OpCopyTo   = 4'h2;
  localparam logic [3:0] OpCopyFrom = 4'h3;
  localparam logic [3:0] OpAdd      = 4'h4;
  localparam logic [3:0] OpSub      = 4'h5;
  localparam logic [3:0] OpBumpUp   = 4'h6;
  localparam logic [3:0] OpBumpDn   = 4'h7;
  localparam logic [3:0] OpJump     = 4'h8;
  localparam logic [3:0] OpJumpZ    = 4'h9;
  localparam logic [3:0] OpJumpN    = 4'hA;
  localparam logic [3:0] OpSet      = 4'hE;
  localparam logic [3:0] OpHalt     = 4'hF;

  localparam logic [STALL_W-1:0] StallLim = STALL_W'(STALL_LIMIT);

  typedef enum logic [2:0] {
    StFetch, StDecode, StAddr, StIndir, StExec, StWait, StStep, StHalt
  } state_e;

  typedef struct packed {
    logic       wIR;
    logic       wR;
    logic       wM;
    logic       wAR;
    logic       wPC;
    logic       rIn;
    logic       wO;
    logic [1:0] muxR;
    logic       srcA;
    logic [2:0] aluCtl;
    logic       ijump;
    logic       branch;
  } strobe_t;

  state_e             stateQ, stateD;
  logic [3:0]         opQ;
  logic               indQ;
  logic               nxtPrevQ;
  strobe_t            strbQ;
  logic               haltQ;
  logic               stallToQ;
  logic [STALL_W-1:0] stallCntQ;
  logic [STALL_W-1:0] stallInc;
  logic [CNT_W-1:0]   instrCntQ;

  logic [3:0] opIn;
  logic       indIn;
  logic       memOp;
  logic       ioWait;
  logic       stepEdge;
  logic       unusedInstr;

  assign opIn        = bus.INSTR[INSTR_W-1 -: 4];
  assign indIn       = bus.INSTR[INSTR_W-5];
  assign unusedInstr = ^bus.INSTR[INSTR_W-6:0];
  assign memOp       = (opIn >= OpCopyTo) && (opIn <= OpBumpDn);
  assign ioWait      = ((opQ == OpInbox) && bus.inEmpty) || ((opQ == OpOutbox) && bus.outFull);
  assign stepEdge    = bus.nxtInstr && !nxtPrevQ;
  assign stallInc    = stallCntQ + 1'b1;

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StFetch:  stateD = memOp ? StAddr : StDecode;
      StDecode: begin
        if (opQ == OpHalt)  stateD = StHalt;
        else if (ioWait)    stateD = StWait;
        else                stateD = StExec;
      end
      StAddr:   stateD = indQ ? StIndir : StExec;
      StIndir:  stateD = StExec;
      StWait:   if (!ioWait) stateD = StExec;
      StExec:   stateD = bus.debug ? StStep : StFetch;
      StStep:   if (!bus.debug || stepEdge) stateD = StFetch;
      StHalt:   stateD = StHalt;
      default:  stateD = StFetch;
    endcase
  end

  // Strobes are registered from the current state, so each appears the cycle after its state.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      stateQ    <= StFetch;
      opQ       <= '0;
      indQ      <= 1'b0;
      nxtPrevQ  <= 1'b0;
      strbQ     <= '0;
      haltQ     <= 1'b0;
      stallToQ  <= 1'b0;
      stallCntQ <= '0;
      instrCntQ <= '0;
    end else begin
      stateQ   <= stateD;
      nxtPrevQ <= bus.nxtInstr;
      strbQ    <= '0;
      if (stateQ == StFetch) begin
        opQ  <= opIn;
        indQ <= indIn;
      end
      case (stateQ)
        StFetch: strbQ.wIR <= 1'b1;
        StAddr:  strbQ.wAR <= 1'b1;
        StIndir: begin
          strbQ.wAR  <= 1'b1;
          strbQ.srcA <= 1'b1;
        end
        StExec: begin
          strbQ.wPC <= 1'b1;
          instrCntQ <= instrCntQ + 1'b1;
          case (opQ)
            OpInbox:    begin strbQ.rIn <= 1'b1; strbQ.wR <= 1'b1; strbQ.muxR <= 2'b00; end
            OpOutbox:   strbQ.wO <= 1'b1;
            OpCopyTo:   strbQ.wM <= 1'b1;
            OpCopyFrom: begin strbQ.wR <= 1'b1; strbQ.muxR <= 2'b01; end
            OpAdd:      begin strbQ.wR <= 1'b1; strbQ.muxR <= 2'b10; strbQ.aluCtl <= 3'b000; end
            OpSub:      begin strbQ.wR <= 1'b1; strbQ.muxR <= 2'b10; strbQ.aluCtl <= 3'b001; end
            OpBumpUp: begin
              strbQ.wR <= 1'b1; strbQ.wM <= 1'b1; strbQ.muxR <= 2'b10; strbQ.aluCtl <= 3'b010;
            end
            OpBumpDn: begin
              strbQ.wR <= 1'b1; strbQ.wM <= 1'b1; strbQ.muxR <= 2'b10; strbQ.aluCtl <= 3'b011;
            end
            OpJump:     strbQ.ijump <= 1'b1;
            OpJumpZ:    begin strbQ.ijump <= bus.zero; strbQ.branch <= bus.zero; end
            OpJumpN:    begin strbQ.ijump <= bus.neg;  strbQ.branch <= bus.neg;  end
            OpSet:      begin strbQ.wR <= 1'b1; strbQ.muxR <= 2'b11; end
            default:    ;
          endcase
        end
        StHalt:  haltQ <= 1'b1;
        default: ;
      endcase
      if (stateQ == StWait) begin
        if (stallCntQ != '1) stallCntQ <= stallInc;
        if ((STALL_LIMIT != 0) && (stallCntQ != '1) && (stallInc == StallLim)) stallToQ <= 1'b1;
      end else begin
        stallCntQ <= '0;
      end
    end
  end

  assign bus.wIR       = strbQ.wIR;
  assign bus.wR        = strbQ.wR;
  assign bus.wM        = strbQ.wM;
  assign bus.wAR       = strbQ.wAR;
  assign bus.wPC       = strbQ.wPC;
  assign bus.rIn       = strbQ.rIn;
  assign bus.wO        = strbQ.wO;
  assign bus.muxR      = strbQ.muxR;
  assign bus.srcA      = strbQ.srcA;
  assign bus.aluCtl    = strbQ.aluCtl;
  assign bus.ijump     = strbQ.ijump;
  assign bus.branch    = strbQ.branch;
  assign bus.halt      = haltQ;
  assign bus.stall_to  = stallToQ;
  assign bus.instr_cnt = instrCntQ;

endmodule

// File: tb/tb_hrm_ctrl_seq.sv
// Self-checking bench for hrm_ctrl_seq: table of instructions plus hand-written stall,
// indirect, debug-step, reset and halt sequences; retires are checked against a scoreboard.
module tb_hrm_ctrl_seq;

  logic clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 clk = ~clk;

  hrm_ctrl_seq_if #(.INSTR_W(8), .CNT_W(16)) bus ();

  hrm_ctrl_seq #(
    .INSTR_W(8), .CNT_W(16), .STALL_W(8), .STALL_LIMIT(200)
  ) dut (
    .clk  (clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  // Retire vector: {wIR,wAR,wR,wM,rIn,wO,muxR[1:0],aluCtl[2:0],ijump,branch}
  typedef struct {
    logic [12:0] vec;
    int          lat;   // cycles from wIR to wPC, 0 = not checked (stalled)
  } exp_t;

  typedef struct {
    logic [7:0]  instr;
    logic        z;
    logic        n;
    logic [12:0] vec;
    int          lat;
  } row_t;

  exp_t sb[$];
  row_t tbl[17];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   irCycle = 0;
  int   rInSeen = 0;
  int   wOSeen = 0;
  int   wIRSeen = 0;
  bit   retired = 1'b0;
  logic [15:0] cnt0;

  function automatic logic [12:0] mk(logic r, logic m, logic ri, logic o, logic [1:0] mx,
                                     logic [2:0] alu, logic ij, logic br);
    return {1'b0, 1'b0, r, m, ri, o, mx, alu, ij, br};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle; also acts as the retire monitor popping the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cycle++;
    if (bus.wIR) begin irCycle = cycle; wIRSeen++; end
    if (bus.rIn) rInSeen++;
    if (bus.wO)  wOSeen++;
    if (bus.wPC) begin
      retired = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_retire", 64'(bus.wPC), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("retire_strobes", 64'({bus.wIR, bus.wAR, bus.wR, bus.wM, bus.rIn, bus.wO, bus.muxR,
                                   bus.aluCtl, bus.ijump, bus.branch}), 64'(e.vec));
        if (e.lat != 0) chk("retire_latency", 64'(cycle - irCycle), 64'(e.lat));
      end
    end
  endtask

  task automatic waitRetire(input int budget, input string nm);
    retired = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (retired) break;
    end
    if (!retired) chk({nm, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic runInstr(input logic [7:0] ins, input logic z, input logic n,
                          input logic [12:0] vec, input int lat);
    exp_t e;
    bus.INSTR = ins;
    bus.zero  = z;
    bus.neg   = n;
    e.vec = vec;
    e.lat = lat;
    sb.push_back(e);
    waitRetire(40, "retire");
  endtask

  task automatic pushNop();
    exp_t e;
    e.vec = mk(0, 0, 0, 0, 2'b00, 3'b000, 0, 0);
    e.lat = 2;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    tbl[0]  = '{8'h00, 1'b0, 1'b0, mk(1, 0, 1, 0, 2'b00, 3'b000, 0, 0), 2};
    tbl[1]  = '{8'h10, 1'b0, 1'b0, mk(0, 0, 0, 1, 2'b00, 3'b000, 0, 0), 2};
    tbl[2]  = '{8'h20, 1'b0, 1'b0, mk(0, 1, 0, 0, 2'b00, 3'b000, 0, 0), 2};
    tbl[3]  = '{8'h30, 1'b0, 1'b0, mk(1, 0, 0, 0, 2'b01, 3'b000, 0, 0), 2};
    tbl[4]  = '{8'h40, 1'b0, 1'b0, mk(1, 0, 0, 0, 2'b10, 3'b000, 0, 0), 2};
    tbl[5]  = '{8'h50, 1'b0, 1'b0, mk(1, 0, 0, 0, 2'b10, 3'b001, 0, 0), 2};
    tbl[6]  = '{8'h60, 1'b0, 1'b0, mk(1, 1, 0, 0, 2'b10, 3'b010, 0, 0), 2};
    tbl[7]  = '{8'h70, 1'b0, 1'b0, mk(1, 1, 0, 0, 2'b10, 3'b011, 0, 0), 2};
    tbl[8]  = '{8'h48, 1'b0, 1'b0, mk(1, 0, 0, 0, 2'b10, 3'b000, 0, 0), 3};
    tbl[9]  = '{8'h80, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00, 3'b000, 1, 0), 2};
    tbl[10] = '{8'h90, 1'b0, 1'b1, mk(0, 0, 0, 0, 2'b00, 3'b000, 0, 0), 2};
    tbl[11] = '{8'h90, 1'b1, 1'b0, mk(0, 0, 0, 0, 2'b00, 3'b000, 1, 1), 2};
    tbl[12] = '{8'hA0, 1'b0, 1'b1, mk(0, 0, 0, 0, 2'b00, 3'b000, 1, 1), 2};
    tbl[13] = '{8'hA0, 1'b1, 1'b0, mk(0, 0, 0, 0, 2'b00, 3'b000, 0, 0), 2};
    tbl[14] = '{8'hB0, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00, 3'b000, 0, 0), 2};
    tbl[15] = '{8'hDC, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00, 3'b000, 0, 0), 2};
    tbl[16] = '{8'hE0, 1'b0, 1'b0, mk(1, 0, 0, 0, 2'b11, 3'b000, 0, 0), 2};

    bus.INSTR = 8'h00; bus.inEmpty = 1'b1; bus.outFull = 1'b0;
    bus.zero = 1'b0; bus.neg = 1'b0; bus.debug = 1'b0; bus.nxtInstr = 1'b0;

    // Reset state
    tick(); tick();
    chk("reset_outputs", 64'({bus.wIR, bus.wR, bus.wM, bus.wAR, bus.wPC, bus.rIn, bus.wO,
                              bus.muxR, bus.srcA, bus.aluCtl, bus.ijump, bus.branch,
                              bus.halt, bus.stall_to, bus.instr_cnt}), 64'(0));

    // INBOX stalled 15 cycles
    e.vec = mk(1, 0, 1, 0, 2'b00, 3'b000, 0, 0);
    e.lat = 0;
    sb.push_back(e);
    i_rst = 1'b1;
    rInSeen = 0;
    for (int i = 0; i < 15; i++) tick();
    chk("inbox_no_early_rin", 64'(rInSeen), 64'(0));
    bus.inEmpty = 1'b0;
    waitRetire(10, "inbox");
    chk("inbox_rin_once", 64'(rInSeen), 64'(1));
    chk("inbox_cnt", 64'(bus.instr_cnt), 64'(1));

    // Table-driven single instructions
    for (int i = 0; i < 17; i++)
      runInstr(tbl[i].instr, tbl[i].z, tbl[i].n, tbl[i].vec, tbl[i].lat);
    chk("table_cnt", 64'(bus.instr_cnt), 64'(18));

    // COPYTO indirect: wAR/srcA=0, wAR/srcA=1, wM on consecutive cycles
    bus.INSTR = 8'h28;
    e.vec = mk(0, 1, 0, 0, 2'b00, 3'b000, 0, 0);
    e.lat = 3;
    sb.push_back(e);
    retired = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.wAR) break;
    end
    chk("indir_a0", 64'({bus.wAR, bus.srcA}), 64'(2'b10));
    tick();
    chk("indir_a1", 64'({bus.wAR, bus.srcA}), 64'(2'b11));
    tick();
    chk("indir_wm", 64'({bus.wM, bus.wPC, bus.wAR}), 64'(3'b110));

    // OUTBOX stall past the timeout
    bus.INSTR = 8'h10;
    bus.outFull = 1'b1;
    e.vec = mk(0, 0, 0, 1, 2'b00, 3'b000, 0, 0);
    e.lat = 0;
    sb.push_back(e);
    wOSeen = 0;
    for (int i = 0; i < 180; i++) tick();
    chk("stall_to_early", 64'(bus.stall_to), 64'(0));
    for (int i = 0; i < 70; i++) tick();
    chk("stall_to_set", 64'(bus.stall_to), 64'(1));
    chk("outbox_no_early_wo", 64'(wOSeen), 64'(0));
    bus.outFull = 1'b0;
    waitRetire(10, "outbox");
    chk("outbox_wo_once", 64'(wOSeen), 64'(1));
    chk("stall_to_sticky", 64'(bus.stall_to), 64'(1));

    // Single-step debug
    bus.debug = 1'b1;
    runInstr(8'hB0, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00, 3'b000, 0, 0), 2);
    cnt0 = bus.instr_cnt;
    for (int k = 0; k < 3; k++) begin
      pushNop();
      bus.nxtInstr = 1'b1;
      tick(); tick();
      bus.nxtInstr = 1'b0;
      for (int i = 0; i < 10; i++) tick();
    end
    chk("step_three", 64'(bus.instr_cnt), 64'(cnt0 + 16'd3));
    pushNop();
    bus.nxtInstr = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("step_held_once", 64'(bus.instr_cnt), 64'(cnt0 + 16'd4));
    bus.nxtInstr = 1'b0;
    tick();
    pushNop();
    bus.debug = 1'b0;
    waitRetire(10, "debug_exit");
    chk("debug_exit_cnt", 64'(bus.instr_cnt), 64'(cnt0 + 16'd5));

    // Asynchronous reset in the middle of an EXEC cycle
    runInstr(8'hE0, 1'b0, 1'b0, mk(1, 0, 0, 0, 2'b11, 3'b000, 0, 0), 2);
    #1 i_rst = 1'b0;
    #1;
    chk("async_reset", 64'({bus.wIR, bus.wR, bus.wM, bus.wAR, bus.wPC, bus.rIn, bus.wO,
                            bus.muxR, bus.srcA, bus.aluCtl, bus.ijump, bus.branch,
                            bus.halt, bus.stall_to, bus.instr_cnt}), 64'(0));
    tick(); tick();
    e.vec = mk(1, 0, 0, 0, 2'b11, 3'b000, 0, 0);
    e.lat = 2;
    sb.push_back(e);
    i_rst = 1'b1;
    retired = 1'b0;
    tick();
    chk("post_reset_wir", 64'(bus.wIR), 64'(1));
    waitRetire(10, "post_reset");
    chk("post_reset_cnt", 64'(bus.instr_cnt), 64'(1));

    // HALT is sticky
    bus.INSTR = 8'hF0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.halt) break;
    end
    chk("halt_set", 64'(bus.halt), 64'(1));
    bus.INSTR = 8'h00;
    wIRSeen = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("halt_sticky", 64'(bus.halt), 64'(1));
    chk("halt_no_fetch", 64'(wIRSeen), 64'(0));
    chk("halt_cnt", 64'(bus.instr_cnt), 64'(1));
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
